// File: rtl/imm_pack_unit.sv
// Packs a signed immediate into its I/S/B/U instruction bit positions [31:7] and flags unrepresentable values.
// Two-stage valid/ready pipeline, 2-cycle latency, 1 result/cycle; a stalled output holds and backpressures upstream.
module imm_pack_unit #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          ImmIn,
  input  logic [1:0]           ImmType,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [24:0]          ImmField,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_U = 2'b11
  } imm_type_e;

  logic                 r_s1_vld;
  logic [31:0]          r_s1_imm;
  imm_type_e            r_s1_type;
  logic                 r_s1_ok;
  logic                 r_s2_vld;
  logic [24:0]          r_s2_field;
  logic                 r_s2_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_s2_load;
  logic                 w_in_rdy;
  logic                 w_ok;
  logic [24:0]          w_enc;
  logic                 w_out_xfer;

  // Stage 2 frees up whenever the consumer takes its result; stage 1 follows it.
  assign w_s2_load  = !r_s2_vld || out_ready;
  assign w_in_rdy   = !r_s1_vld || w_s2_load;
  assign w_out_xfer = r_s2_vld && out_ready;

  assign in_ready  = w_in_rdy;
  assign out_valid = r_s2_vld;
  assign ImmField  = r_s2_field;
  assign out_err   = r_s2_err;
  assign err_count = r_err_cnt;

  always_comb begin
    w_ok = 1'b0;
    case (imm_type_e'(ImmType))
      IMM_I, IMM_S: w_ok = (&ImmIn[31:11]) || !(|ImmIn[31:11]);
      IMM_B:        w_ok = ((&ImmIn[31:12]) || !(|ImmIn[31:12])) && !ImmIn[0];
      IMM_U:        w_ok = !(|ImmIn[11:0]);
      default:      w_ok = 1'b0;
    endcase
  end

  // Bits not belonging to the chosen format stay zero.
  always_comb begin
    w_enc = '0;
    case (r_s1_type)
      IMM_I: w_enc[24:13] = r_s1_imm[11:0];
      IMM_S: begin
        w_enc[24:18] = r_s1_imm[11:5];
        w_enc[4:0]   = r_s1_imm[4:0];
      end
      IMM_B: begin
        w_enc[24]    = r_s1_imm[12];
        w_enc[23:18] = r_s1_imm[10:5];
        w_enc[4:1]   = r_s1_imm[4:1];
        w_enc[0]     = r_s1_imm[11];
      end
      IMM_U: w_enc[24:5] = r_s1_imm[31:12];
      default: w_enc = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_imm  <= '0;
      r_s1_type <= IMM_I;
      r_s1_ok   <= 1'b0;
    end else if (w_in_rdy) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_imm  <= ImmIn;
        r_s1_type <= imm_type_e'(ImmType);
        r_s1_ok   <= w_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld   <= 1'b0;
      r_s2_field <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_field <= w_enc;
        r_s2_err   <= !r_s1_ok;
      end
    end
  end

  // Clear wins over a coincident erroneous delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_out_xfer && r_s2_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_imm_pack_unit.sv
// Scoreboard bench for imm_pack_unit: directed format cases, backpressure, error counter, reset, random traffic.
module tb_imm_pack_unit;

  typedef struct packed {
    logic [24:0] f;
    logic        e;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ImmIn;
  logic [1:0]  ImmType;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] ImmField;
  logic        out_err;
  logic [7:0]  err_count;
  logic        err_clr;

  logic        rnd_ordy;
  logic        rnd_bit;
  logic        ordy_man;

  exp_t        q[$];
  int          n_chk;
  int          n_fail;
  int          n_acc;
  int          n_out;
  int          mdl_cnt;
  logic        hold_v;
  exp_t        hold_d;

  assign out_ready = rnd_ordy ? rnd_bit : ordy_man;

  imm_pack_unit #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmIn     (ImmIn),
    .ImmType   (ImmType),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ImmField  (ImmField),
    .out_err   (out_err),
    .err_count (err_count),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: place immediate bits in a full 32-bit instruction word, judge range with signed arithmetic.
  function automatic exp_t ref_model(input logic [1:0] t, input logic [31:0] imm);
    logic [31:0] instr;
    longint      v;
    bit          ok;
    exp_t        r;
    instr = '0;
    v = longint'($signed(imm));
    ok = 1'b0;
    case (t)
      2'd0: begin
        instr[31:20] = imm[11:0];
        ok = (v >= -2048) && (v <= 2047);
      end
      2'd1: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        ok = (v >= -2048) && (v <= 2047);
      end
      2'd2: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
        ok = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      end
      default: begin
        instr[31:12] = imm[31:12];
        ok = (imm % 4096) == 0;
      end
    endcase
    r.f = instr[31:7];
    r.e = !ok;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Monitor: scoreboard pop, output hold check and error-counter model.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      exp_t e;
      if (hold_v) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {6'd0, ImmField, out_err}, {6'd0, hold_d});
      end
      chk("err_count", {24'd0, err_count}, mdl_cnt);
      e = '0;
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got field 0x%0h, required no output", ImmField);
        end else begin
          e = q.pop_front();
          chk("field", {7'd0, ImmField}, {7'd0, e.f});
          chk("err", {31'd0, out_err}, {31'd0, e.e});
        end
      end
      if (err_clr) mdl_cnt = 0;
      else if (out_valid && out_ready && e.e && mdl_cnt < 255) mdl_cnt++;
      hold_v = out_valid && !out_ready;
      hold_d = {ImmField, out_err};
    end
  end

  task automatic send(input logic [1:0] t, input logic [31:0] imm);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    ImmType  = t;
    ImmIn    = imm;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(ref_model(t, imm));
        n_acc++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [31:0] imm;
    exp_t        cap;
    int          n0;
    n_chk = 0; n_fail = 0; n_acc = 0; n_out = 0; mdl_cnt = 0;
    hold_v = 1'b0; hold_d = '0;
    rst_n = 1'b0; in_valid = 1'b0; ImmIn = '0; ImmType = '0; err_clr = 1'b0;
    rnd_ordy = 1'b0; ordy_man = 1'b1; rnd_bit = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_field", {7'd0, ImmField}, 0);
    chk("rst_out_err", {31'd0, out_err}, 0);
    chk("rst_err_count", {24'd0, err_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // I-type with 2-cycle latency check
    send(2'd0, 32'hFFFFF800);
    chk("lat_cycle1", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", {31'd0, out_valid}, 1);
    chk("lat_field", {7'd0, ImmField}, 32'h1000000);
    send(2'd0, 32'h00000800);
    drain();
    chk("errcnt_one", {24'd0, err_count}, 1);
    send(2'd2, 32'h00000FFE);
    send(2'd2, 32'h00000003);
    send(2'd3, 32'h12345000);
    send(2'd3, 32'h12345001);
    send(2'd1, 32'hFFFFFFFF);
    drain();

    // Backpressure: only two requests fit while the output is stalled
    ordy_man = 1'b0;
    fork
      begin
        send(2'd0, 32'h00000011);
        send(2'd1, 32'hFFFFF812);
        send(2'd2, 32'h00000124);
        send(2'd3, 32'hABCDE000);
      end
      begin
        n0 = n_acc;
        repeat (5) @(posedge clk);
        #2;
        chk("bp_accepted", n_acc - n0, 2);
        chk("bp_in_ready", {31'd0, in_ready}, 0);
        cap = {ImmField, out_err};
        repeat (2) @(posedge clk);
        #2;
        chk("bp_stable", {6'd0, ImmField, out_err}, {6'd0, cap});
        n0 = n_out;
        ordy_man = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("bp_one_per_cycle", n_out - n0, 4);
      end
    join
    drain();

    // Error counter saturation, then clear coincident with an erroneous delivery
    for (int i = 0; i < 300; i++) send(2'd0, 32'h00000800);
    drain();
    chk("errcnt_sat", {24'd0, err_count}, 255);
    send(2'd3, 32'h00000001);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("clr_setup_valid", {31'd0, out_valid}, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("errcnt_clr", {24'd0, err_count}, 0);
    drain();

    // Random traffic with random consumer stalls
    rnd_ordy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      imm = $urandom;
      case ($urandom_range(0, 4))
        0: ;
        1: imm[31:11] = imm[11] ? '1 : '0;
        2: begin imm[31:12] = imm[12] ? '1 : '0; imm[0] = 1'b0; end
        3: imm[11:0] = '0;
        default: imm = $urandom_range(0, 8191);
      endcase
      send(2'($urandom_range(0, 3)), imm);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ordy = 1'b0;
    ordy_man = 1'b1;
    drain();

    // Reset with two requests in flight
    send(2'd2, 32'h00000001);
    drain();
    ordy_man = 1'b0;
    send(2'd0, 32'h00000800);
    send(2'd1, 32'h00000005);
    @(posedge clk);
    #1;
    chk("rf_pre_valid", {31'd0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_out_valid", {31'd0, out_valid}, 0);
    chk("rf_err_count", {24'd0, err_count}, 0);
    q.delete();
    mdl_cnt = 0;
    ordy_man = 1'b1;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rf_in_ready", {31'd0, in_ready}, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rf_no_ghost", {31'd0, out_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_pack_unit.md
IMM_PACK_UNIT -- requirements
Module: imm_pack_unit

Interface
REQ-001 The block SHALL have parameter ERR_CNT_W, default 8, which sets the width of the saturating error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-006 The block SHALL have port ImmIn, input, 32 bits: the signed immediate value to encode.
REQ-007 The block SHALL have port ImmType, input, 2 bits: the format, 00=I, 01=S, 10=B, 11=U.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the encoded result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port ImmField, output, 25 bits: the immediate bits placed at instruction positions [31:7] (ImmField[0] = instr[7]); non-immediate bit positions SHALL be 0.
REQ-011 The block SHALL have port out_err, output, 1 bit: ImmIn was not representable in ImmType.
REQ-012 The block SHALL have port err_count, output, ERR_CNT_W bits: the saturating count of results delivered with out_err=1.
REQ-013 The block SHALL have port err_clr, input, 1 bit: a synchronous clear of err_count.

Function
REQ-014 Encoding SHALL be as follows:
- I: ImmField[24:13] = ImmIn[11:0].
- S: ImmField[24:18] = ImmIn[11:5]; ImmField[4:0] = ImmIn[4:0].
- B: ImmField[24] = ImmIn[12]; ImmField[23:18] = ImmIn[10:5]; ImmField[4:1] = ImmIn[4:1]; ImmField[0] = ImmIn[11].
- U: ImmField[24:5] = ImmIn[31:12].
REQ-015 Representability SHALL be as follows:
- I and S: ImmIn[31:11] all equal.
- B: ImmIn[31:12] all equal and ImmIn[0] = 0.
- U: ImmIn[11:0] = 0.
REQ-016 An unrepresentable input SHALL still produce the truncated encoding of REQ-014, with out_err=1; the block SHALL NOT drop the request.
REQ-017 The block SHALL be a two-stage pipeline:
- Stage 1 registers ImmIn, ImmType and the representability flag.
- Stage 2 registers ImmField and out_err.
REQ-018 A transfer SHALL occur on a cycle with in_valid and in_ready both high; latency from acceptance to out_valid SHALL be exactly 2 cycles when out_ready is held high.
REQ-019 Stage 2 SHALL load when it is empty or out_ready=1; stage 1 SHALL advance when stage 2 loads.
REQ-020 in_ready SHALL equal (stage 1 empty) OR (stage 1 advances this cycle).
REQ-021 Sustained throughput SHALL be 1 result per cycle while out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, ImmField and out_err SHALL hold stable, and out_valid SHALL NOT drop.
REQ-023 Results SHALL leave in acceptance order; no request SHALL be lost or duplicated under any in_valid/out_ready pattern.
REQ-024 err_count SHALL increment by 1 on each output transfer (out_valid and out_ready) with out_err=1, and SHALL saturate at 2^ERR_CNT_W-1.
REQ-025 If err_clr=1, err_count SHALL become 0 on that edge; err_clr SHALL take priority over a simultaneous erroneous transfer, which is not counted.
REQ-026 in_ready SHALL depend combinationally only on out_ready and internal state, never on in_valid.

Reset
REQ-027 While rst_n=0, both stages SHALL be empty, out_valid=0, ImmField=0, out_err=0 and err_count=0, taking effect immediately without a clock edge.
REQ-028 Assertion of rst_n mid-operation SHALL discard all in-flight requests; in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Verification
REQ-029 Scenario, I-type range:
- I, ImmIn=0xFFFFF800 -> ImmField=0x1000000, out_err=0, 2 cycles after acceptance.
- I, ImmIn=0x00000800 -> ImmField=0x1000000, out_err=1, err_count=1.
REQ-030 Scenario, B-type:
- B, ImmIn=0x00000FFE -> ImmField=0x0FC001F, out_err=0.
- B, ImmIn=0x00000003 -> out_err=1.
REQ-031 Scenario, U and S:
- U, ImmIn=0x12345000 -> ImmField=0x02468A0, out_err=0.
- U, ImmIn=0x12345001 -> out_err=1.
- S, ImmIn=0xFFFFFFFF -> ImmField=0x1FC001F, out_err=0.
REQ-032 Scenario, backpressure: 4 back-to-back requests with out_ready=0 -> in_ready low after 2 accepted, outputs held stable; raise out_ready -> all 4 results delivered in order, one per cycle, none lost.
REQ-033 Scenario, error counter: 300 erroneous transfers -> err_count saturates at 255. err_clr coincident with an erroneous transfer -> err_count=0 on the next cycle.
REQ-034 Scenario, reset mid-flight: 2 requests in flight, pulse rst_n low between clock edges -> out_valid and err_count drop to 0 immediately; in_ready=1 on the first cycle after release.
